mips_mc_control: RTL and testbench
==================================

# mips_mc_control

Multicycle control unit for the Small-MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. On every cycle it drives the datapath mux selects, the write enables, and the 4-bit `alu` control code consumed on the ALU's `i_control` port. It sits between the instruction register / zero flag and the shared datapath, and is the producer side of the ALU control interface.

## Interface
Parameters: none; all encodings come from `mips_pkg`.

- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  asynchronous active-low reset
- `i_opcode`  in  6  IR[31:26]
- `i_funct`  in  6  IR[5:0]
- `i_zf`  in  1  ALU `o_zf` of the current cycle
- `o_pc_en`  out  1  PC load = pc_write | (branch & i_zf)
- `o_iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `o_mem_write`  out  1  data memory write
- `o_ir_write`  out  1  instruction register load
- `o_reg_dst`  out  1  destination select: 0 = rt, 1 = rd
- `o_mem_to_reg`  out  1  writeback source: 0 = ALUOut, 1 = MDR
- `o_reg_write`  out  1  register file write
- `o_alu_src_a`  out  1  ALU A: 0 = PC, 1 = register A
- `o_alu_src_b`  out  2  ALU B: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `o_pc_src`  out  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `o_alu_control`  out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
- `o_illegal`  out  1  one-cycle pulse in DECODE for an unsupported opcode or funct
- `o_state`  out  4  current state, for debug

## Operation
- Supported instructions:
  - R-type (opcode 000000) with funct add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010
  - lw 100011, sw 101011, beq 000100, addi 001000, j 000010
- States and transitions:
  - IDLE → FETCH
  - FETCH → DECODE
  - DECODE → one of:
    - MEMADR (lw/sw)
    - EXEC (R-type with a legal funct)
    - BRANCH (beq)
    - ADDIEX (addi)
    - JUMP (j)
    - FETCH (illegal)
  - MEMADR → MEMRD (lw) or MEMWR (sw)
  - MEMRD → MEMWB → FETCH
  - MEMWR → FETCH
  - EXEC → ALUWB → FETCH
  - ADDIEX → ADDIWB → FETCH
  - BRANCH → FETCH
  - JUMP → FETCH
- Output values are Moore, decoded from the state register. The only exceptions are `o_pc_en` (uses `i_zf`) and `o_alu_control` in EXEC (uses `i_funct`). Every output not listed for a state is 0.
  - IDLE: all outputs 0.
  - FETCH: iord=0, ir_write=1, src_a=0, src_b=01, alu=ADD, pc_src=00, pc_en=1.
  - DECODE: src_a=0, src_b=11, alu=ADD (computes the branch target).
  - MEMADR, ADDIEX: src_a=1, src_b=10, alu=ADD.
  - MEMRD: iord=1.
  - MEMWR: iord=1, mem_write=1.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - EXEC: src_a=1, src_b=00, alu from funct.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - BRANCH: src_a=1, src_b=00, alu=SUB, pc_src=01, pc_en=`i_zf`.
  - JUMP: pc_src=10, pc_en=1.
- Illegal opcode or funct: `o_illegal`=1 in DECODE, then return to FETCH with no register or memory write. The PC has already advanced by 4.

## Timing
- Instruction latency in cycles, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset:
  - `i_rst_n` low forces state=IDLE immediately (asynchronous), so all outputs are 0 and `o_state`=IDLE.
  - First FETCH is on the second rising edge after deassertion: the first edge enters IDLE→FETCH.
  - Reset mid-instruction aborts it with no partial write: outputs drop to 0 combinationally on assertion.
- `i_opcode` and `i_funct` are sampled only in DECODE and EXEC; they are don't-care elsewhere.
- `i_zf` is sampled only in BRANCH. `o_pc_en` follows it combinationally in the same cycle.

## Structure
- `mips_pkg`:
  - ALU control localparams (AND, OR, ADD, SUB, SOLT, NOR)
  - opcode and funct constants
  - 4-bit state encoding
  - `o_alu_src_b` / `o_pc_src` select codes
- Sub-module `alu_decoder`, combinational, reused by the single-cycle core. Inputs: 2-bit alu_op (00 = ADD, 01 = SUB, 10 = funct) and 6-bit funct. Outputs: 4-bit control and a `legal` flag.
- Top: state register, next-state logic, output decode.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; `o_state` goes IDLE → FETCH; FETCH shows ir_write=1, pc_en=1, alu=0010.
- R-type with funct 101010 (slt) → exactly 4 cycles; EXEC alu=0111, src_a=1, src_b=00; ALUWB reg_write=1, reg_dst=1. Repeat for funct 100111 → alu=1100.
- lw then sw → lw takes 5 cycles, with MEMWB mem_to_reg=1; sw takes 4 cycles, with mem_write=1 for exactly one cycle at iord=1; no reg_write.
- beq with `i_zf`=1 and then with `i_zf`=0 → BRANCH alu=0110, pc_src=01; pc_en=1 only when `i_zf`=1; 3 cycles each.
- opcode 111111, then R-type funct 000000 → `o_illegal` pulses once in DECODE; next state FETCH; reg_write and mem_write stay 0.
- `i_rst_n` asserted during MEMWR → mem_write drops to 0 without waiting for a clock edge; after release, sequencing resumes from IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the Small-MIPS control path: ALU codes, opcodes, functs,
// multicycle state encoding and datapath select codes.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_e;

    // Non-R-type opcodes the core implements; R-type legality depends on funct.
    function automatic logic is_itype_known(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder shared with the single-cycle core: fixed ADD/SUB or
// funct-driven control, plus a legality flag for the funct field.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_control,
    output logic       o_legal
);

    always_comb begin
        o_control = ALU_ADD;
        o_legal   = 1'b1;
        case (i_alu_op)
            ALUOP_ADD: o_control = ALU_ADD;
            ALUOP_SUB: o_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    F_ADD:   o_control = ALU_ADD;
                    F_SUB:   o_control = ALU_SUB;
                    F_AND:   o_control = ALU_AND;
                    F_OR:    o_control = ALU_OR;
                    F_NOR:   o_control = ALU_NOR;
                    F_SLT:   o_control = ALU_SLT;
                    default: begin
                        o_control = ALU_AND;
                        o_legal   = 1'b0;
                    end
                endcase
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle control FSM for the Small-MIPS datapath: sequences each
// instruction and decodes Moore-style datapath controls from the state register.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_zf,
    output logic       o_pc_en,
    output logic       o_iord,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_pc_src,
    output logic [3:0] o_alu_control,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    state_e     state_q;
    logic       store_q;
    logic [1:0] alu_op;
    logic [3:0] dec_control;
    logic       dec_legal;
    logic       instr_legal;

    alu_decoder u_alu_decoder (
        .i_alu_op (alu_op),
        .i_funct  (i_funct),
        .o_control(dec_control),
        .o_legal  (dec_legal)
    );

    // In DECODE the decoder runs in funct mode only to judge R-type legality.
    assign instr_legal = (i_opcode == OP_RTYPE) ? dec_legal : is_itype_known(i_opcode);

    // Opcode is only valid during DECODE, so lw/sw is remembered for MEMADR.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            store_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  state_q <= S_FETCH;
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    store_q <= (i_opcode == OP_SW);
                    if (!instr_legal) begin
                        state_q <= S_FETCH;
                    end else begin
                        case (i_opcode)
                            OP_LW, OP_SW: state_q <= S_MEMADR;
                            OP_RTYPE:     state_q <= S_EXEC;
                            OP_BEQ:       state_q <= S_BRANCH;
                            OP_ADDI:      state_q <= S_ADDIEX;
                            OP_J:         state_q <= S_JUMP;
                            default:      state_q <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: state_q <= store_q ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_q <= S_MEMWB;
                S_MEMWB:  state_q <= S_FETCH;
                S_MEMWR:  state_q <= S_FETCH;
                S_EXEC:   state_q <= S_ALUWB;
                S_ALUWB:  state_q <= S_FETCH;
                S_ADDIEX: state_q <= S_ADDIWB;
                S_ADDIWB: state_q <= S_FETCH;
                S_BRANCH: state_q <= S_FETCH;
                S_JUMP:   state_q <= S_FETCH;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_op        = ALUOP_ADD;
        o_pc_en       = 1'b0;
        o_iord        = 1'b0;
        o_mem_write   = 1'b0;
        o_ir_write    = 1'b0;
        o_reg_dst     = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_reg_write   = 1'b0;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = SRCB_B;
        o_pc_src      = PCSRC_ALU;
        o_alu_control = 4'b0000;
        o_illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                o_ir_write    = 1'b1;
                o_alu_src_b   = SRCB_FOUR;
                o_alu_control = dec_control;
                o_pc_en       = 1'b1;
            end
            S_DECODE: begin
                alu_op        = ALUOP_FUNCT;
                o_alu_src_b   = SRCB_IMM_SH;
                o_alu_control = ALU_ADD;
                o_illegal     = ~instr_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                o_alu_src_a   = 1'b1;
                o_alu_src_b   = SRCB_IMM;
                o_alu_control = dec_control;
            end
            S_MEMRD: o_iord = 1'b1;
            S_MEMWR: begin
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
            end
            S_MEMWB: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
            end
            S_EXEC: begin
                alu_op        = ALUOP_FUNCT;
                o_alu_src_a   = 1'b1;
                o_alu_control = dec_control;
            end
            S_ALUWB: begin
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
            end
            S_ADDIWB: o_reg_write = 1'b1;
            S_BRANCH: begin
                alu_op        = ALUOP_SUB;
                o_alu_src_a   = 1'b1;
                o_alu_control = dec_control;
                o_pc_src      = PCSRC_ALUOUT;
                o_pc_en       = i_zf;
            end
            S_JUMP: begin
                o_pc_src = PCSRC_JUMP;
                o_pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: per-instruction cycle tables built
// from the instruction-level rules and compared cycle by cycle against the DUT.
module tb_mips_mc_control;
    import mips_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [5:0] i_opcode, i_funct;
    logic       i_zf;
    logic       o_pc_en, o_iord, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg;
    logic       o_reg_write, o_alu_src_a, o_illegal;
    logic [1:0] o_alu_src_b, o_pc_src;
    logic [3:0] o_alu_control, o_state;

    mips_mc_control dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_funct(i_funct),
        .i_zf(i_zf), .o_pc_en(o_pc_en), .o_iord(o_iord), .o_mem_write(o_mem_write),
        .o_ir_write(o_ir_write), .o_reg_dst(o_reg_dst), .o_mem_to_reg(o_mem_to_reg),
        .o_reg_write(o_reg_write), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
        .o_pc_src(o_pc_src), .o_alu_control(o_alu_control), .o_illegal(o_illegal),
        .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    // pcm: 0 = pc_en low, 1 = pc_en high, 2 = pc_en follows i_zf
    typedef struct packed {
        logic [3:0] st;
        logic [1:0] pcm;
        logic       iord, mw, irw, rd, m2r, rw, sa;
        logic [1:0] sb, ps;
        logic [3:0] alu;
        logic       ill;
    } exp_t;
    typedef logic [20:0] vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    vec_t obs_q[$];
    logic zf_q[$];

    function automatic vec_t obs_now();
        return {o_state, o_pc_en, o_iord, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
                o_reg_write, o_alu_src_a, o_alu_src_b, o_pc_src, o_alu_control, o_illegal};
    endfunction

    function automatic vec_t expv(input exp_t e, input logic zf);
        logic pe;
        pe = (e.pcm == 2'd2) ? zf : e.pcm[0];
        return {e.st, pe, e.iord, e.mw, e.irw, e.rd, e.m2r, e.rw, e.sa, e.sb, e.ps, e.alu, e.ill};
    endfunction

    // {legal, alu code} for an R-type funct
    function automatic logic [4:0] funct_model(input logic [5:0] fn);
        case (fn)
            6'b100000: return {1'b1, 4'b0010};
            6'b100010: return {1'b1, 4'b0110};
            6'b100100: return {1'b1, 4'b0000};
            6'b100101: return {1'b1, 4'b0001};
            6'b100111: return {1'b1, 4'b1100};
            6'b101010: return {1'b1, 4'b0111};
            default:   return 5'b0;
        endcase
    endfunction

    function automatic void build(input logic [5:0] op, input logic [5:0] fn);
        exp_t e;
        logic [4:0] fm;
        logic legal;
        exp_q.delete();
        fm = funct_model(fn);
        legal = (op == 6'b000000) ? fm[4] :
                (op == 6'b100011 || op == 6'b101011 || op == 6'b000100 ||
                 op == 6'b001000 || op == 6'b000010);
        e = '0; e.st = S_FETCH; e.irw = 1; e.sb = 2'b01; e.alu = 4'b0010; e.pcm = 2'd1;
        exp_q.push_back(e);
        e = '0; e.st = S_DECODE; e.sb = 2'b11; e.alu = 4'b0010; e.ill = ~legal;
        exp_q.push_back(e);
        if (!legal) return;
        case (op)
            6'b100011, 6'b101011: begin
                e = '0; e.st = S_MEMADR; e.sa = 1; e.sb = 2'b10; e.alu = 4'b0010;
                exp_q.push_back(e);
                if (op == 6'b100011) begin
                    e = '0; e.st = S_MEMRD; e.iord = 1; exp_q.push_back(e);
                    e = '0; e.st = S_MEMWB; e.m2r = 1; e.rw = 1; exp_q.push_back(e);
                end else begin
                    e = '0; e.st = S_MEMWR; e.iord = 1; e.mw = 1; exp_q.push_back(e);
                end
            end
            6'b000000: begin
                e = '0; e.st = S_EXEC; e.sa = 1; e.alu = fm[3:0]; exp_q.push_back(e);
                e = '0; e.st = S_ALUWB; e.rd = 1; e.rw = 1; exp_q.push_back(e);
            end
            6'b000100: begin
                e = '0; e.st = S_BRANCH; e.sa = 1; e.alu = 4'b0110; e.ps = 2'b01; e.pcm = 2'd2;
                exp_q.push_back(e);
            end
            6'b001000: begin
                e = '0; e.st = S_ADDIEX; e.sa = 1; e.sb = 2'b10; e.alu = 4'b0010;
                exp_q.push_back(e);
                e = '0; e.st = S_ADDIWB; e.rw = 1; exp_q.push_back(e);
            end
            default: begin
                e = '0; e.st = S_JUMP; e.ps = 2'b10; e.pcm = 2'd1; exp_q.push_back(e);
            end
        endcase
    endfunction

    // Drives one instruction starting in FETCH; IR fields are only valid in DECODE/EXEC.
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input int zmode);
        obs_q.delete();
        zf_q.delete();
        foreach (exp_q[i]) begin
            if (exp_q[i].st == S_DECODE || exp_q[i].st == S_EXEC) begin
                i_opcode = op; i_funct = fn;
            end else begin
                i_opcode = 6'($urandom); i_funct = 6'($urandom);
            end
            i_zf = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            @(negedge i_clk);
            obs_q.push_back(obs_now());
            zf_q.push_back(i_zf);
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_opcode = 6'b0; i_funct = 6'b0; i_zf = 1'b1;
        for (int c = 0; c < 3; c++) begin
            i_opcode = 6'($urandom); i_zf = 1'($urandom_range(0, 1));
            @(negedge i_clk);
            n_checks++;
            if (obs_now() !== 21'h0) begin
                n_fail++; $display("FAIL reset_hold cyc%0d got %h want 000000", c, obs_now());
            end
        end
        @(posedge i_clk); #1; i_rst_n = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (obs_now() !== 21'h0) begin
            n_fail++; $display("FAIL reset_idle got %h want 000000", obs_now());
        end
        @(posedge i_clk); #1;
        n_checks++;
        if (o_state !== S_FETCH) begin
            n_fail++; $display("FAIL reset_first_fetch state got %0d want %0d", o_state, S_FETCH);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns[4];
        fns = '{6'b101010, 6'b100111, 6'b100000, 6'b100101};
        for (int k = 0; k < 4; k++) begin
            build(6'b000000, fns[k]);
            drive(6'b000000, fns[k], 2);
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== expv(exp_q[i], zf_q[i])) begin
                    n_fail++; $display("FAIL rtype_f%b cyc%0d got %h want %h", fns[k], i, obs_q[i], expv(exp_q[i], zf_q[i]));
                end
            end
            n_checks++;
            if (o_state !== S_FETCH) begin
                n_fail++; $display("FAIL rtype_latency state got %0d want %0d", o_state, S_FETCH);
            end
        end
    endtask

    task automatic test_mem();
        logic [5:0] ops[2];
        int mw_cnt, rw_cnt;
        ops = '{6'b100011, 6'b101011};
        for (int k = 0; k < 2; k++) begin
            build(ops[k], 6'($urandom));
            drive(ops[k], 6'($urandom), 2);
            mw_cnt = 0; rw_cnt = 0;
            foreach (exp_q[i]) begin
                mw_cnt += int'(obs_q[i][14]);
                rw_cnt += int'(obs_q[i][10]);
                n_checks++;
                if (obs_q[i] !== expv(exp_q[i], zf_q[i])) begin
                    n_fail++; $display("FAIL mem_op%b cyc%0d got %h want %h", ops[k], i, obs_q[i], expv(exp_q[i], zf_q[i]));
                end
            end
            n_checks++;
            if (mw_cnt !== ((k == 1) ? 1 : 0) || rw_cnt !== ((k == 1) ? 0 : 1)) begin
                n_fail++; $display("FAIL mem_write_counts op%b got mw=%0d rw=%0d want mw=%0d rw=%0d", ops[k], mw_cnt, rw_cnt, k, 1 - k);
            end
            n_checks++;
            if (o_state !== S_FETCH) begin
                n_fail++; $display("FAIL mem_latency state got %0d want %0d", o_state, S_FETCH);
            end
        end
    endtask

    task automatic test_branch();
        for (int z = 1; z >= 0; z--) begin
            build(6'b000100, 6'($urandom));
            drive(6'b000100, 6'($urandom), z);
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== expv(exp_q[i], zf_q[i])) begin
                    n_fail++; $display("FAIL beq_zf%0d cyc%0d got %h want %h", z, i, obs_q[i], expv(exp_q[i], zf_q[i]));
                end
            end
            n_checks++;
            if (o_state !== S_FETCH) begin
                n_fail++; $display("FAIL beq_latency state got %0d want %0d", o_state, S_FETCH);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops[2], fns[2];
        int ill_cnt, wr_cnt;
        ops = '{6'b111111, 6'b000000};
        fns = '{6'b100000, 6'b000000};
        for (int k = 0; k < 2; k++) begin
            build(ops[k], fns[k]);
            drive(ops[k], fns[k], 2);
            ill_cnt = 0; wr_cnt = 0;
            foreach (exp_q[i]) begin
                ill_cnt += int'(obs_q[i][0]);
                wr_cnt  += int'(obs_q[i][10]) + int'(obs_q[i][14]);
                n_checks++;
                if (obs_q[i] !== expv(exp_q[i], zf_q[i])) begin
                    n_fail++; $display("FAIL illegal%0d cyc%0d got %h want %h", k, i, obs_q[i], expv(exp_q[i], zf_q[i]));
                end
            end
            n_checks++;
            if (ill_cnt !== 1 || wr_cnt !== 0 || o_state !== S_FETCH) begin
                n_fail++; $display("FAIL illegal%0d_summary got ill=%0d wr=%0d state=%0d want 1 0 %0d", k, ill_cnt, wr_cnt, o_state, S_FETCH);
            end
        end
    endtask

    task automatic test_reset_mid();
        build(6'b101011, 6'b0);
        for (int c = 0; c < 3; c++) begin
            i_opcode = 6'b101011; i_funct = 6'b0; i_zf = 1'b0;
            @(posedge i_clk); #1;
        end
        n_checks++;
        if (o_mem_write !== 1'b1 || o_state !== S_MEMWR) begin
            n_fail++; $display("FAIL rstmid_pre got mw=%b state=%0d want 1 %0d", o_mem_write, o_state, S_MEMWR);
        end
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_now() !== 21'h0) begin
            n_fail++; $display("FAIL rstmid_async got %h want 000000", obs_now());
        end
        @(posedge i_clk); #1; i_rst_n = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_state !== S_IDLE) begin
            n_fail++; $display("FAIL rstmid_idle state got %0d want %0d", o_state, S_IDLE);
        end
        @(posedge i_clk); #1;
        build(6'b100011, 6'b0);
        drive(6'b100011, 6'b0, 2);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== expv(exp_q[i], zf_q[i])) begin
                n_fail++; $display("FAIL rstmid_resume cyc%0d got %h want %h", i, obs_q[i], expv(exp_q[i], zf_q[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[6], fns[6];
        logic [5:0] op, fn;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            build(op, fn);
            drive(op, fn, 2);
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== expv(exp_q[i], zf_q[i])) begin
                    n_fail++; $display("FAIL random%0d op%b fn%b cyc%0d got %h want %h", n, op, fn, i, obs_q[i], expv(exp_q[i], zf_q[i]));
                end
            end
        end
        n_checks++;
        if (o_state !== S_FETCH) begin
            n_fail++; $display("FAIL random_end state got %0d want %0d", o_state, S_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_branch();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
